// File: rtl/key_arb_pkg.sv
// -----------------------------------------------------------------------------
// key_arb_pkg
// Shared definitions for the key event arbiter:
//   DEF_NUM_KEYS / DEF_IDX_W : default key count and key-index width
//   state_t                  : arbiter FSM states (IDLE, OFFER)
//   key_evt_t                : one note event {key index, press flag}
//   wrap_inc()               : index + 1 with wrap at n-1 (works for any n)
// -----------------------------------------------------------------------------
package key_arb_pkg;

    localparam int DEF_NUM_KEYS = 8;
    localparam int DEF_IDX_W    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_IDX_W-1:0] key;
        logic                 press;
    } key_evt_t;

    // Explicit compare instead of a power-of-2 modulo so odd key counts wrap
    // correctly.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/key_event_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans the request vector starting at
// i_rr_ptr, wrapping from NUM_KEYS-1 back to 0, and returns the first set bit.
// The loop walks the rotated order directly, which is the rotate / find-first /
// unrotate operation folded into one pass.
// Ports:
//   i_req      in  NUM_KEYS  request vector
//   i_rr_ptr   in  IDX_W     index with highest priority this cycle
//   o_any_req  out 1         at least one request is set
//   o_winner   out IDX_W     granted index (0 when no request)
// -----------------------------------------------------------------------------
module rr_pick
    import key_arb_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic [NUM_KEYS-1:0] i_req,
    input  logic [IDX_W-1:0]    i_rr_ptr,
    output logic                o_any_req,
    output logic [IDX_W-1:0]    o_winner
);

    int               w_idx;
    logic [IDX_W-1:0] w_idx_v;
    logic             w_found;

    always_comb begin
        o_any_req = |i_req;
        o_winner  = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        w_idx_v   = '0;
        for (int j = 0; j < NUM_KEYS; j++) begin
            w_idx = j + int'(i_rr_ptr);
            if (w_idx >= NUM_KEYS) begin
                w_idx = w_idx - NUM_KEYS;
            end
            w_idx_v = IDX_W'(w_idx);
            if (!w_found && i_req[w_idx_v]) begin
                w_found  = 1'b1;
                o_winner = w_idx_v;
            end
        end
    end

endmodule

// File: rtl/key_event_arbiter.sv
// -----------------------------------------------------------------------------
// key_event_arbiter
// Collects per-key press/release pulses, keeps at most one pending press and
// one pending release per key, and offers them one at a time on a single
// valid/ready note-event channel in round-robin key order.
//
// Handshake: evt_valid rises with evt_key/evt_press already stable; all three
// hold unchanged until the cycle where evt_valid && evt_ready, which is the
// transfer. evt_valid then drops for exactly one cycle before the next offer.
//
// Optional feature (macro KEY_HOLD_TRACK_EN):
//   defined   : held_keys tracks accepted presses/releases; a release for a
//               key that is not held is silently consumed without an offer.
//   undefined : held_keys = 0 and every pending edge is offered.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   key_press       NUM_KEYS 1-cycle press pulses
//   key_release     NUM_KEYS 1-cycle release pulses
//   evt_valid       event offered
//   evt_ready       consumer accepts
//   evt_key         key index of offered event
//   evt_press       1 = press, 0 = release
//   overflow        1-cycle pulse when an edge merged into a pending edge
//   held_keys       key-down map (0 unless KEY_HOLD_TRACK_EN)
//   dbg_state       FSM state
//   dbg_rr_ptr      round-robin pointer
// -----------------------------------------------------------------------------
module key_event_arbiter
    import key_arb_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_press,
    input  logic [NUM_KEYS-1:0] key_release,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [IDX_W-1:0]    evt_key,
    output logic                evt_press,
    output logic                overflow,
    output logic [NUM_KEYS-1:0] held_keys,
    output state_t              dbg_state,
    output logic [IDX_W-1:0]    dbg_rr_ptr
);

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_KEYS-1:0] r_pend_p;
    logic [NUM_KEYS-1:0] r_pend_r;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_evt_key;
    logic                r_evt_press;
    logic                r_overflow;

    logic [NUM_KEYS-1:0] w_req;
    logic                w_any_req;
    logic [IDX_W-1:0]    w_winner;
    logic                w_win_press;
    logic                w_accept;
    logic                w_drop;
    logic                w_load;
    logic [NUM_KEYS-1:0] w_clr_p;
    logic [NUM_KEYS-1:0] w_clr_r;
    logic [NUM_KEYS-1:0] w_merge;
    logic [IDX_W-1:0]    w_ptr_next;

    assign w_req = r_pend_p | r_pend_r;

    rr_pick #(
        .NUM_KEYS (NUM_KEYS),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .i_req     (w_req),
        .i_rr_ptr  (r_rr_ptr),
        .o_any_req (w_any_req),
        .o_winner  (w_winner)
    );

    // Press wins over release within the same key.
    assign w_win_press = r_pend_p[w_winner];
    assign w_accept    = (r_state == OFFER) && evt_ready;

`ifdef KEY_HOLD_TRACK_EN
    logic [NUM_KEYS-1:0] r_held;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held <= '0;
        end else if (w_accept) begin
            r_held[r_evt_key] <= r_evt_press;
        end
    end

    // A release for a key that is not down is consumed straight from IDLE.
    assign w_drop    = (r_state == IDLE) && w_any_req && !w_win_press && !r_held[w_winner];
    assign held_keys = r_held;
`else
    assign w_drop    = 1'b0;
    assign held_keys = '0;
`endif

    // FSM next-state
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req && !w_drop) begin
                    w_load       = 1'b1;
                    w_next_state = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Pending-bit clears and pointer advance for the served (or dropped) edge.
    always_comb begin
        w_clr_p    = '0;
        w_clr_r    = '0;
        w_ptr_next = r_rr_ptr;
        if (w_accept) begin
            if (r_evt_press) begin
                w_clr_p[r_evt_key] = 1'b1;
            end else begin
                w_clr_r[r_evt_key] = 1'b1;
            end
            // Stay on this key when its release is still waiting so the
            // release follows the press directly.
            if (r_evt_press && r_pend_r[r_evt_key]) begin
                w_ptr_next = r_evt_key;
            end else begin
                w_ptr_next = IDX_W'(wrap_inc(int'(r_evt_key), NUM_KEYS));
            end
        end else if (w_drop) begin
            w_clr_r[w_winner] = 1'b1;
            w_ptr_next        = IDX_W'(wrap_inc(int'(w_winner), NUM_KEYS));
        end
    end

    // An edge landing on the cycle its bit is cleared re-arms the bit and is
    // not a merge.
    assign w_merge = (key_press & r_pend_p & ~w_clr_p) | (key_release & r_pend_r & ~w_clr_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pend_p    <= '0;
            r_pend_r    <= '0;
            r_rr_ptr    <= '0;
            r_evt_key   <= '0;
            r_evt_press <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pend_p   <= (r_pend_p & ~w_clr_p) | key_press;
            r_pend_r   <= (r_pend_r & ~w_clr_r) | key_release;
            r_rr_ptr   <= w_ptr_next;
            r_overflow <= |w_merge;
            if (w_load) begin
                r_evt_key   <= w_winner;
                r_evt_press <= w_win_press;
            end
        end
    end

    assign evt_valid  = (r_state == OFFER);
    assign evt_key    = r_evt_key;
    assign evt_press  = r_evt_press;
    assign overflow   = r_overflow;
    assign dbg_state  = r_state;
    assign dbg_rr_ptr = r_rr_ptr;

endmodule
